// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbitration of NUM_REQ byte producers onto a
// single 8N1 UART transmitter. The bit-period counter restarts at every frame
// so bit edges line up with the start bit.
// Optional feature: define UART_TX_PARITY_EN to append an even-parity bit
// between the last data bit and the stop bit (8E1 framing).
module uart_tx_arbiter #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int NUM_REQ    = 4,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_W-1:0]     owner,
  output logic                 busy,
  output logic                 tx
);

  localparam int BIT_CYCLES = CLOCK_RATE / BAUD_RATE;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    even_parity = ^b;
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;
`endif

  // Registered state and outputs
  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2:0]           bit_idx_r;
  logic [7:0]           shift_r;
  logic [IDX_W-1:0]     ptr_r;
  logic [IDX_W-1:0]     owner_r;
  logic                 busy_r;
  logic                 tx_r;
  logic [NUM_REQ-1:0]   grant_r;
`ifdef UART_TX_PARITY_EN
  logic                 par_r;
  logic                 par_s;
`endif

  // Next-state values
  state_t               state_s;
  logic [CNT_W-1:0]     cnt_s;
  logic [2:0]           bit_idx_s;
  logic [7:0]           shift_s;
  logic [IDX_W-1:0]     ptr_s;
  logic [IDX_W-1:0]     owner_s;
  logic                 busy_s;
  logic                 tx_s;
  logic [NUM_REQ-1:0]   grant_s;

  // Arbitration results
  logic                 found_s;
  logic [IDX_W-1:0]     sel_s;
  logic [NUM_REQ-1:0]   onehot_s;
  logic [7:0]           sel_data_s;
  logic [IDX_W-1:0]     next_ptr_s;
  logic                 cnt_last_s;

  assign grant = grant_r;
  assign owner = owner_r;
  assign busy  = busy_r;
  assign tx    = tx_r;

  assign cnt_last_s = (cnt_r == CNT_LAST);
  assign next_ptr_s = (sel_s == IDX_LAST) ? '0 : (sel_s + IDX_W'(1'b1));

  // Round-robin search: first requester at or above the pointer, else wrap to the lowest.
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && req[i] && (IDX_W'(i) >= ptr_r)) begin
        found_s = 1'b1;
        sel_s   = IDX_W'(i);
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && req[i]) begin
        found_s = 1'b1;
        sel_s   = IDX_W'(i);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Decode the winner into a one-hot grant and pick its byte.
  always_comb begin
    onehot_s   = '0;
    sel_data_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found_s && (sel_s == IDX_W'(i))) begin
        onehot_s[i] = 1'b1;
        sel_data_s  = data[8*i +: 8];
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
  end

  // Frame sequencing: next state, bit timing and next values of every register.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    ptr_s     = ptr_r;
    owner_s   = owner_r;
    busy_s    = busy_r;
    tx_s      = tx_r;
    grant_s   = '0;
`ifdef UART_TX_PARITY_EN
    par_s     = par_r;
`endif
    case (state_r)
      ST_IDLE: begin
        cnt_s     = '0;
        bit_idx_s = 3'd0;
        tx_s      = 1'b1;
        busy_s    = 1'b0;
        if (found_s) begin
          grant_s = onehot_s;
          shift_s = sel_data_s;
          owner_s = sel_s;
          ptr_s   = next_ptr_s;
          tx_s    = 1'b0;
          busy_s  = 1'b1;
          state_s = ST_START;
`ifdef UART_TX_PARITY_EN
          par_s   = even_parity(sel_data_s);
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_last_s) begin
          cnt_s     = '0;
          bit_idx_s = 3'd0;
          tx_s      = shift_r[0];
          shift_s   = {1'b0, shift_r[7:1]};
          state_s   = ST_DATA;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      ST_DATA: begin
        if (cnt_last_s) begin
          cnt_s = '0;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_s    = par_r;
            state_s = ST_PARITY;
`else
            tx_s    = 1'b1;
            state_s = ST_STOP;
`endif
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
            tx_s      = shift_r[0];
            shift_s   = {1'b0, shift_r[7:1]};
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (cnt_last_s) begin
          cnt_s   = '0;
          tx_s    = 1'b1;
          state_s = ST_STOP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
`endif
      ST_STOP: begin
        if (cnt_last_s) begin
          cnt_s   = '0;
          tx_s    = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      default: begin
        cnt_s   = '0;
        tx_s    = 1'b1;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the line to idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      ptr_r     <= '0;
      owner_r   <= '0;
      busy_r    <= 1'b0;
      tx_r      <= 1'b1;
      grant_r   <= '0;
`ifdef UART_TX_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      ptr_r     <= ptr_s;
      owner_r   <= owner_s;
      busy_r    <= busy_s;
      tx_r      <= tx_s;
      grant_r   <= grant_s;
`ifdef UART_TX_PARITY_EN
      par_r     <= par_s;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter with CLOCK_RATE=8, BAUD_RATE=1 (8 clocks per bit).
// A line monitor decodes every frame on tx into obs_q; tests push the frames
// they expect into exp_q, and test_scoreboard pairs them up at the end.
module tb_uart_tx_arbiter;

  localparam int BC = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int TOT = NBITS * BC;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic        tx;

  typedef struct { logic [1:0] idx; logic [7:0] data; } exp_t;
  typedef struct { logic [1:0] owner; logic [7:0] data; logic start; logic par; logic stop; } frame_t;

  exp_t   exp_q[$];
  frame_t obs_q[$];

  int checks = 0;
  int passed = 0;
  int proto_err = 0;

  uart_tx_arbiter #(.CLOCK_RATE(8), .BAUD_RATE(1), .NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data),
    .grant(grant), .owner(owner), .busy(busy), .tx(tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line monitor: decodes frames mid-bit and checks grant legality.
  initial begin
    logic [NBITS-1:0] mon_bits;
    int     mon_ticks;
    bit     mon_active;
    logic [1:0] mon_owner;
    logic   prev_busy;
    frame_t f;
    mon_active = 1'b0;
    mon_ticks  = 0;
    prev_busy  = 1'b0;
    mon_bits   = '0;
    mon_owner  = 2'd0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mon_active = 1'b0;
        prev_busy  = 1'b0;
      end else begin
        if (grant !== 4'b0000) begin
          if ($countones(grant) != 1 || prev_busy === 1'b1) proto_err++;
        end
        prev_busy = busy;
        if (!mon_active) begin
          if (tx === 1'b0) begin
            mon_active = 1'b1;
            mon_ticks  = 0;
            mon_owner  = owner;
          end
        end else begin
          mon_ticks++;
          if (mon_ticks % BC == BC / 2) mon_bits[mon_ticks / BC] = tx;
          if (mon_ticks == TOT - 1) begin
            f.owner = mon_owner;
            f.data  = mon_bits[8:1];
            f.start = mon_bits[0];
            f.stop  = mon_bits[NBITS-1];
`ifdef UART_TX_PARITY_EN
            f.par   = mon_bits[9];
`else
            f.par   = 1'b0;
`endif
            obs_q.push_back(f);
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    req   = 4'hF;
    data  = 32'h13121110;
    @(negedge clk);
    @(negedge clk);
    checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else passed++;
    checks++; if (owner !== 2'd0) $display("FAIL reset_owner: got %0d want 0", owner); else passed++;
    rst_n = 1'b1;
    req   = 4'b0000;
    bad   = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || grant !== 4'b0000) bad++;
    end
    checks++; if (bad != 0) $display("FAIL reset_idle: got %0d active cycles want 0", bad); else passed++;
  endtask

  task automatic test_single_byte();
    logic [NBITS-1:0] fr;
    int bad_tx, bad_busy, bad_grant;
    apply_reset();
`ifdef UART_TX_PARITY_EN
    fr = {1'b1, ^(8'hA5), 8'hA5, 1'b0};
`else
    fr = {1'b1, 8'hA5, 1'b0};
`endif
    @(posedge clk);
    #1;
    data[7:0] = 8'hA5;
    req = 4'b0001;
    exp_q.push_back('{2'd0, 8'hA5});
    @(negedge clk);
    checks++; if (grant !== 4'b0000) $display("FAIL single_latency: got %b want 0000", grant); else passed++;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) $display("FAIL single_grant: got %b want 0001", grant); else passed++;
    req = 4'b0000;
    bad_tx = 0; bad_busy = 0; bad_grant = 0;
    for (int c = 0; c < TOT; c++) begin
      if (c > 0) @(negedge clk);
      if (tx !== fr[c / BC]) bad_tx++;
      if (busy !== 1'b1) bad_busy++;
      if (c > 0 && grant !== 4'b0000) bad_grant++;
    end
    checks++; if (bad_tx != 0) $display("FAIL single_tx_shape: got %0d wrong cycles want 0", bad_tx); else passed++;
    checks++; if (bad_busy != 0) $display("FAIL single_busy_hold: got %0d low cycles want 0", bad_busy); else passed++;
    checks++; if (bad_grant != 0) $display("FAIL single_grant_pulse: got %0d extra cycles want 0", bad_grant); else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tx !== 1'b1) $display("FAIL single_end: got busy=%b tx=%b want busy=0 tx=1", busy, tx); else passed++;
  endtask

  task automatic test_parity();
    int cyc, nbusy;
    apply_reset();
    @(posedge clk);
    #1;
    data[15:8] = 8'h01;
    req = 4'b0010;
    exp_q.push_back('{2'd1, 8'h01});
    cyc = 0;
    while (grant === 4'b0000 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (grant !== 4'b0010) $display("FAIL parity_grant: got %b want 0010", grant); else passed++;
    req = 4'b0000;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 2 * TOT) begin
      nbusy++;
      @(negedge clk);
    end
    checks++; if (nbusy != TOT) $display("FAIL parity_busy_len: got %0d want %0d", nbusy, TOT); else passed++;
  endtask

  task automatic test_round_robin();
    int ng, cyc, last;
    logic [3:0] exp_g;
    apply_reset();
    @(posedge clk);
    #1;
    data = 32'h13121110;
    req  = 4'hF;
    for (int k = 0; k < 5; k++) exp_q.push_back('{2'(k % 4), 8'h10 + 8'(k % 4)});
    ng = 0; cyc = 0; last = 0;
    while (ng < 5 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (grant !== 4'b0000) begin
        exp_g = 4'b0001 << (ng % 4);
        checks++; if (grant !== exp_g) $display("FAIL rr_order%0d: got %b want %b", ng, grant, exp_g); else passed++;
        if (ng > 0) begin
          checks++; if (cyc - last != TOT + 1) $display("FAIL rr_gap%0d: got %0d want %0d", ng, cyc - last, TOT + 1); else passed++;
        end
        last = cyc;
        ng++;
        if (ng == 5) req = 4'b0000;
      end
    end
    checks++; if (ng != 5) $display("FAIL rr_timeout: got %0d grants want 5", ng); else passed++;
    cyc = 0;
    while (busy === 1'b1 && cyc < 2 * TOT) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_fairness();
    int ng, cyc;
    logic [3:0] exp_g;
    apply_reset();
    @(posedge clk);
    #1;
    data[23:16] = 8'h42;
    req = 4'b0100;
    exp_q.push_back('{2'd2, 8'h42});
    cyc = 0;
    while (grant === 4'b0000 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (grant !== 4'b0100) $display("FAIL fair_first: got %b want 0100", grant); else passed++;
    req = 4'b0000;
    repeat (20) @(negedge clk);
    data[15:8]  = 8'h31;
    data[31:24] = 8'h73;
    req = 4'b1010;
    exp_q.push_back('{2'd3, 8'h73});
    exp_q.push_back('{2'd1, 8'h31});
    ng = 0; cyc = 0;
    while (ng < 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (grant !== 4'b0000) begin
        exp_g = (ng == 0) ? 4'b1000 : 4'b0010;
        checks++; if (grant !== exp_g) $display("FAIL fair_order%0d: got %b want %b", ng, grant, exp_g); else passed++;
        req = req & ~grant;
        ng++;
      end
    end
    checks++; if (ng != 2) $display("FAIL fair_timeout: got %0d grants want 2", ng); else passed++;
    cyc = 0;
    while (busy === 1'b1 && cyc < 2 * TOT) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_abort();
    int cyc, bad;
    apply_reset();
    @(posedge clk);
    #1;
    data[7:0] = 8'h5A;
    req = 4'b0001;
    cyc = 0;
    while (grant === 4'b0000 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (grant !== 4'b0001) $display("FAIL abort_grant: got %b want 0001", grant); else passed++;
    req = 4'b0000;
    repeat (29) @(negedge clk);
    checks++; if (busy !== 1'b1 || tx !== 1'b0) $display("FAIL abort_midframe: got busy=%b tx=%b want busy=1 tx=0", busy, tx); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) $display("FAIL abort_tx: got %b want 1", tx); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (grant !== 4'b0000 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL abort_quiet: got %0d active cycles want 0", bad); else passed++;
  endtask

  task automatic test_scoreboard();
    exp_t   e;
    frame_t f;
    logic   exp_par;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL sb_count: got %0d frames want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      f = obs_q.pop_front();
`ifdef UART_TX_PARITY_EN
      exp_par = ^e.data;
`else
      exp_par = 1'b0;
`endif
      checks++; if (f.data !== e.data) $display("FAIL sb_data: got %h want %h", f.data, e.data); else passed++;
      checks++; if (f.owner !== e.idx) $display("FAIL sb_owner: got %0d want %0d", f.owner, e.idx); else passed++;
      checks++;
      if (f.start !== 1'b0 || f.stop !== 1'b1 || f.par !== exp_par)
        $display("FAIL sb_framing: got start=%b par=%b stop=%b want start=0 par=%b stop=1", f.start, f.par, f.stop, exp_par);
      else passed++;
    end
  endtask

  task automatic test_protocol();
    checks++; if (proto_err != 0) $display("FAIL grant_legality: got %0d violations want 0", proto_err); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    data  = 32'h0;
    test_reset();
    test_single_byte();
    test_parity();
    test_round_robin();
    test_fairness();
    test_abort();
    test_scoreboard();
    test_protocol();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
